// File: rtl/calc_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : calc_cmd_queue
//  Description : Command front end for the 8-bit accumulator calculator.
//                Buffers (opcode, operand) pairs in a FIFO and replays them
//                as single-cycle enable strobes. After each issue it samples
//                the calculator flags and can halt on overflow until resumed.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int OPW   = 4,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_op,
    input  logic [DW-1:0]            in_data,
    input  logic                     hold,
    input  logic                     halt_on_ovf,
    input  logic                     resume,
    input  logic                     flush,
    input  logic [2:0]               flags_in,
    output logic                     out_en,
    output logic [OPW-1:0]           out_op,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted,
    output logic [7:0]               skip_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = OPW + DW;

    // Opcodes the calculator does not implement; they are dropped unissued.
    localparam logic [OPW-1:0] c_OP_RSVD_A = OPW'(4'hB);
    localparam logic [OPW-1:0] c_OP_RSVD_B = OPW'(4'hC);
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(DEPTH);
    localparam logic [7:0]      c_SKIP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_EW-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_in_ready;
    logic               r_out_en;
    logic [OPW-1:0]     r_out_op;
    logic [DW-1:0]      r_out_data;
    logic               r_halted;
    logic [7:0]         r_skip_cnt;

    logic [c_EW-1:0]    w_head;
    logic [OPW-1:0]     w_head_op;
    logic [DW-1:0]      w_head_data;
    logic               w_head_rsvd;
    logic               w_nonempty;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic               w_skip;
    logic [c_CW-1:0]    w_count_nxt;

    // Only the overflow flag steers the sequencer; neg/zero pass through
    // to software elsewhere.
    logic               w_unused_flags;
    assign w_unused_flags = ^flags_in[1:0];

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[c_EW-1:DW];
    assign w_head_data = w_head[DW-1:0];
    assign w_head_rsvd = (w_head_op == c_OP_RSVD_A) || (w_head_op == c_OP_RSVD_B);
    assign w_nonempty  = (r_count != '0);

    // A push is gated by the registered ready, so a same-cycle pop never
    // makes room for it; flush drops any concurrent push.
    assign w_push = in_valid && r_in_ready && !flush;

    // Sequencer: decides pops, issues and skips for this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_skip      = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_nonempty && !hold) begin
                        w_pop = 1'b1;
                        if (w_head_rsvd) begin
                            w_skip = 1'b1;
                        end else begin
                            w_issue     = 1'b1;
                            w_state_nxt = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    w_state_nxt = S_CHECK;
                end
                S_CHECK: begin
                    if (halt_on_ovf && flags_in[2]) begin
                        w_state_nxt = S_HALT;
                    end else if (w_nonempty && !hold && !w_head_rsvd) begin
                        // Back-to-back issue; reserved heads go via IDLE to be skipped.
                        w_pop       = 1'b1;
                        w_issue     = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Occupancy after this edge; flush empties the queue outright.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + c_CW'(1);
                2'b01:   w_count_nxt = r_count - c_CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_op, in_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != c_FULL);
        end
    end

    // Calculator strobe and operand registers; operands hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_en   <= 1'b0;
            r_out_op   <= '0;
            r_out_data <= '0;
        end else begin
            r_out_en <= w_issue;
            if (w_issue) begin
                r_out_op   <= w_head_op;
                r_out_data <= w_head_data;
            end
        end
    end

    // Status: halt indicator and saturating count of discarded opcodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted   <= 1'b0;
            r_skip_cnt <= '0;
        end else begin
            r_halted <= (w_state_nxt == S_HALT);
            if (w_skip && (r_skip_cnt != c_SKIP_MAX)) begin
                r_skip_cnt <= r_skip_cnt + 8'd1;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign out_en   = r_out_en;
    assign out_op   = r_out_op;
    assign out_data = r_out_data;
    assign count    = r_count;
    assign halted   = r_halted;
    assign skip_cnt = r_skip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_calc_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_cmd_queue
//  Description : Self-checking bench for calc_cmd_queue: hand-computed vector
//                table, directed corner sequences and randomized traffic
//                compared against a queue-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc_cmd_queue;

    localparam int DEPTH = 8;
    localparam int OPW   = 4;
    localparam int DW    = 8;

    logic       clk = 1'b0;
    logic       rst, in_valid, hold, halt_on_ovf, resume, flush;
    logic [3:0] in_op;
    logic [7:0] in_data;
    logic [2:0] flags_in;
    logic       in_ready, out_en, halted;
    logic [3:0] out_op;
    logic [7:0] out_data;
    logic [3:0] count;
    logic [7:0] skip_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    calc_cmd_queue #(.DEPTH(DEPTH), .OPW(OPW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .hold(hold), .halt_on_ovf(halt_on_ovf),
        .resume(resume), .flush(flush), .flags_in(flags_in), .out_en(out_en),
        .out_op(out_op), .out_data(out_data), .count(count), .halted(halted),
        .skip_cnt(skip_cnt)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [3:0] op; logic [7:0] data; } cmd_t;
    cmd_t       mq[$];
    cmd_t       obs[$];
    int         m_phase;   // 0 waiting, 1 strobing, 2 reading flags, 3 halted
    logic       m_en;
    logic [3:0] m_op;
    logic [7:0] m_data;
    logic [7:0] m_skip;

    function automatic bit is_rsvd(input logic [3:0] op);
        return (op == 4'hB) || (op == 4'hC);
    endfunction

    task automatic model_step();
        cmd_t head;
        bit   issued;
        bit   accept;
        int   n;
        if (rst) begin
            mq.delete(); m_phase = 0; m_en = 0; m_op = 0; m_data = 0; m_skip = 0;
            return;
        end
        if (flush) begin
            mq.delete(); m_phase = 0; m_en = 0;
            return;
        end
        n      = mq.size();
        accept = in_valid && (n < DEPTH);
        issued = 0;
        case (m_phase)
            0: if (n > 0 && !hold) begin
                head = mq.pop_front();
                if (is_rsvd(head.op)) begin
                    if (m_skip != 8'hFF) m_skip = m_skip + 8'd1;
                end else begin
                    issued = 1; m_phase = 1;
                end
            end
            1: m_phase = 2;
            2: if (halt_on_ovf && flags_in[2]) m_phase = 3;
               else if (n > 0 && !hold && !is_rsvd(mq[0].op)) begin
                   head = mq.pop_front(); issued = 1; m_phase = 1;
               end else m_phase = 0;
            default: if (resume) m_phase = 0;
        endcase
        m_en = issued;
        if (issued) begin
            m_op = head.op; m_data = head.data;
        end
        if (accept) mq.push_back(cmd_t'{in_op, in_data});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("m.out_en",   32'(out_en),   32'(m_en));
        chk("m.out_op",   32'(out_op),   32'(m_op));
        chk("m.out_data", 32'(out_data), 32'(m_data));
        chk("m.count",    32'(count),    32'(mq.size()));
        chk("m.in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("m.halted",   32'(halted),   32'(m_phase == 3));
        chk("m.skip_cnt", 32'(skip_cnt), 32'(m_skip));
    endtask

    // One clock: inputs already set; advance, update model, sample after edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
        if (out_en === 1'b1) obs.push_back(cmd_t'{out_op, out_data});
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; in_op = 0; in_data = 0; hold = 0;
        halt_on_ovf = 0; resume = 0; flush = 0; flags_in = 3'b000;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       v;
        logic [3:0] op;
        logic [7:0] d;
        logic       e_en;
        logic [3:0] e_op;
        logic [7:0] e_data;
        logic [3:0] e_cnt;
        logic       e_rdy;
        logic [7:0] e_skip;
    } vec_t;

    vec_t vt[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        m_phase = 0; m_en = 0; m_op = 0; m_data = 0; m_skip = 0;

        //          rst v  op    d      en op    data   cnt rdy skip
        vt[0]  = '{1, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 1, 8'd0};
        vt[1]  = '{0, 1, 4'h0, 8'h05, 0, 4'h0, 8'h00, 1, 1, 8'd0};
        vt[2]  = '{0, 1, 4'h1, 8'h03, 1, 4'h0, 8'h05, 1, 1, 8'd0};
        vt[3]  = '{0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h05, 1, 1, 8'd0};
        vt[4]  = '{0, 0, 4'h0, 8'h00, 1, 4'h1, 8'h03, 0, 1, 8'd0};
        vt[5]  = '{0, 0, 4'h0, 8'h00, 0, 4'h1, 8'h03, 0, 1, 8'd0};
        vt[6]  = '{0, 0, 4'h0, 8'h00, 0, 4'h1, 8'h03, 0, 1, 8'd0};
        vt[7]  = '{0, 1, 4'hB, 8'h11, 0, 4'h1, 8'h03, 1, 1, 8'd0};
        vt[8]  = '{0, 1, 4'h2, 8'h0F, 0, 4'h1, 8'h03, 1, 1, 8'd1};
        vt[9]  = '{0, 0, 4'h0, 8'h00, 1, 4'h2, 8'h0F, 0, 1, 8'd1};
        vt[10] = '{0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h0F, 0, 1, 8'd1};
        vt[11] = '{0, 0, 4'h0, 8'h00, 0, 4'h2, 8'h0F, 0, 1, 8'd1};

        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst; in_valid = vt[i].v; in_op = vt[i].op; in_data = vt[i].d;
            cycle();
            chk("t.out_en",   32'(out_en),   32'(vt[i].e_en));
            chk("t.out_op",   32'(out_op),   32'(vt[i].e_op));
            chk("t.out_data", 32'(out_data), 32'(vt[i].e_data));
            chk("t.count",    32'(count),    32'(vt[i].e_cnt));
            chk("t.in_ready", 32'(in_ready), 32'(vt[i].e_rdy));
            chk("t.skip_cnt", 32'(skip_cnt), 32'(vt[i].e_skip));
            chk("t.halted",   32'(halted),   32'(0));
        end
        idle_inputs();

        // ---- fill to DEPTH with consumer held, then drain in order ----
        hold = 1;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_op = 4'(i); in_data = 8'(8'h20 + i);
            cycle();
        end
        chk("fill.count", 32'(count), 32'(8));
        chk("fill.in_ready", 32'(in_ready), 32'(0));
        in_op = 4'h0; in_data = 8'hEE;
        cycle();
        chk("fill.ninth_dropped", 32'(count), 32'(8));
        in_valid = 0; hold = 0;
        obs.delete();
        for (int k = 0; k < 24; k++) cycle();
        chk("drain.strobes", 32'(obs.size()), 32'(8));
        for (int i = 0; i < 8 && i < obs.size(); i++)
            chk("drain.order", 32'(obs[i]), 32'({4'(i), 8'(8'h20 + i)}));
        chk("drain.count", 32'(count), 32'(0));
        chk("drain.in_ready", 32'(in_ready), 32'(1));

        // ---- halt on overflow, then resume ----
        obs.delete();
        halt_on_ovf = 1; flags_in = 3'b100;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1; in_op = 4'(i); in_data = 8'(8'h30 + i);
            cycle();
        end
        in_valid = 0;
        for (int k = 0; k < 4; k++) cycle();
        chk("halt.halted", 32'(halted), 32'(1));
        chk("halt.count", 32'(count), 32'(2));
        chk("halt.strobes", 32'(obs.size()), 32'(1));
        flags_in = 3'b000; resume = 1;
        cycle();
        resume = 0;
        for (int k = 0; k < 8; k++) cycle();
        chk("resume.strobes", 32'(obs.size()), 32'(3));
        if (obs.size() == 3) begin
            chk("resume.second", 32'(obs[1]), 32'({4'h2, 8'h32}));
            chk("resume.third",  32'(obs[2]), 32'({4'h3, 8'h33}));
        end
        chk("resume.halted", 32'(halted), 32'(0));
        chk("resume.count", 32'(count), 32'(0));
        halt_on_ovf = 0;

        // ---- flush with concurrent push while three entries held ----
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_op = 4'h4; in_data = 8'(8'h40 + i);
            cycle();
        end
        chk("flush.pre_count", 32'(count), 32'(3));
        obs.delete();
        flush = 1; in_data = 8'h44;
        cycle();
        chk("flush.count", 32'(count), 32'(0));
        chk("flush.in_ready", 32'(in_ready), 32'(1));
        flush = 0; in_valid = 0; hold = 0;
        for (int k = 0; k < 6; k++) cycle();
        chk("flush.no_strobe", 32'(obs.size()), 32'(0));
        chk("flush.count_after", 32'(count), 32'(0));

        // ---- reset while a strobe is presented ----
        in_valid = 1; in_op = 4'h5; in_data = 8'h55;
        cycle();
        in_op = 4'h6; in_data = 8'h66;
        cycle();
        in_valid = 0;
        for (int k = 0; k < 10 && out_en !== 1'b1; k++) cycle();
        chk("rst.reached_issue", 32'(out_en), 32'(1));
        rst = 1;
        cycle();
        rst = 0;
        chk("rst.out_en", 32'(out_en), 32'(0));
        chk("rst.count", 32'(count), 32'(0));
        chk("rst.in_ready", 32'(in_ready), 32'(1));
        chk("rst.halted", 32'(halted), 32'(0));

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            in_valid    = ($urandom_range(0, 9) < 6);
            in_op       = 4'($urandom_range(0, 15));
            in_data     = 8'($urandom);
            hold        = ($urandom_range(0, 4) == 0);
            halt_on_ovf = ($urandom_range(0, 1) == 1);
            resume      = ($urandom_range(0, 9) == 0);
            flags_in    = 3'($urandom_range(0, 7));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
